// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared types, sizes and golden truth table for the gate sweep checker.
//   state_e         : sweep FSM states
//   NUM_VECTORS     : number of input combinations swept (a,b)
//   SETTLE_CNT_W    : settle counter width (SETTLE_CYCLES legal range 0..15)
//   gate_res_t      : packed {nand, nor, xnor} result bundle
//   expected_gates(): golden {nand, nor, xnor} for a given (a, b)
package gate_sweep_pkg;

    localparam int unsigned NUM_VECTORS  = 4;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned SETTLE_CNT_W = 4;
    localparam int unsigned ERR_CNT_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic nand_r;
        logic nor_r;
        logic xnor_r;
    } gate_res_t;

    // Golden two-input gate truth table.
    function automatic gate_res_t expected_gates(input logic a_v, input logic b_v);
        gate_res_t res;
        res.nand_r = ~(a_v & b_v);
        res.nor_r  = ~(a_v | b_v);
        res.xnor_r = ~(a_v ^ b_v);
        return res;
    endfunction

endpackage

// File: rtl/gate_sweep_ref.sv
// gate_sweep_ref: combinational golden model of the two-input gate block.
//   a_i, b_i       : current stimulus
//   exp_nand_o     : expected ~(a & b)
//   exp_nor_o      : expected ~(a | b)
//   exp_xnor_o     : expected ~(a ^ b)
module gate_sweep_ref
    import gate_sweep_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    output logic exp_nand_o,
    output logic exp_nor_o,
    output logic exp_xnor_o
);

    gate_res_t exp_c;

    assign exp_c      = expected_gates(a_i, b_i);
    assign exp_nand_o = exp_c.nand_r;
    assign exp_nor_o  = exp_c.nor_r;
    assign exp_xnor_o = exp_c.xnor_r;

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives all four (a,b) combinations into a two-input gate
// block, waits SETTLE_CYCLES after each vector, samples nand/nor/xnor and
// compares against a golden model.
//   SETTLE_CYCLES            : wait cycles between driving and sampling (0..15)
//   clk, rst_n               : clock, asynchronous active-low reset
//   start                    : sweep request, honoured only in IDLE or DONE
//   a_nand_b/a_nor_b/a_xnor_b: results from the gate block under test
//   a, b                     : registered stimulus (vector idx = {a, b})
//   busy                     : sweep in progress
//   done                     : level, high in DONE until the next sweep starts
//   pass                     : high in DONE when no vector failed
//   err_count                : number of failing vectors (0..4)
//   err_mask                 : bit i set when vector i failed
// Build option: GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch,
// holding the failing vector on a/b.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 a_nand_b,
    input  logic                 a_nor_b,
    input  logic                 a_xnor_b,
    output logic                 a,
    output logic                 b,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [NUM_VECTORS-1:0] err_mask
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]        IDX_LAST    = IDX_W'(NUM_VECTORS - 1);
    // With no settle time a freshly driven vector is sampled on the very next edge.
    localparam state_e VEC_STATE = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

    state_e                  state_q, state_d;
    logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [ERR_CNT_W-1:0]    err_count_q, err_count_d;
    logic [NUM_VECTORS-1:0]  err_mask_q, err_mask_d;

    logic      exp_nand_c, exp_nor_c, exp_xnor_c;
    logic      mismatch_c;
    logic      finish_c;

    // Golden reference sees the same registered stimulus as the gate block.
    gate_sweep_ref u_ref (
        .a_i        (idx_q[1]),
        .b_i        (idx_q[0]),
        .exp_nand_o (exp_nand_c),
        .exp_nor_o  (exp_nor_c),
        .exp_xnor_o (exp_xnor_c)
    );

    assign mismatch_c = ({a_nand_b, a_nor_b, a_xnor_b} != {exp_nand_c, exp_nor_c, exp_xnor_c});

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_mask_q  <= err_mask_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_mask_d  = err_mask_q;
        finish_c    = (idx_q == IDX_LAST);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        finish_c    = finish_c | mismatch_c;
`endif

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = VEC_STATE;
                    cnt_d       = '0;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    err_mask_d  = '0;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + SETTLE_CNT_W'(1);
                end
            end

            ST_SAMPLE: begin
                if (mismatch_c) begin
                    err_count_d        = err_count_q + ERR_CNT_W'(1);
                    err_mask_d[idx_q]  = 1'b1;
                end
                if (finish_c) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                end else begin
                    state_d = VEC_STATE;
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign a         = idx_q[1];
    assign b         = idx_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign err_mask  = err_mask_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed, table-driven bench for gate_sweep_checker.
// Instance dut uses SETTLE_CYCLES=2, dut0 uses SETTLE_CYCLES=0. Each drives a
// behavioural gate block with a selectable fault.
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start0 = 1'b0;
    int         fault = 0;
    int         fault0 = 0;

    logic       a_o, b_o, busy_o, done_o, pass_o;
    logic [2:0] cnt_o;
    logic [3:0] mask_o;
    logic       nand_g, nor_g, xnor_g;

    logic       a0_o, b0_o, busy0_o, done0_o, pass0_o;
    logic [2:0] cnt0_o;
    logic [3:0] mask0_o;
    logic       nand0_g, nor0_g, xnor0_g;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Gate block with fault selection:
    // 0 good, 1 xnor stuck 0, 2 nand stuck 1, 3 nor stuck 1, 4 all inverted, 5 nor stuck 0
    function automatic logic [2:0] gate_blk(input logic av, input logic bv, input int f);
        logic n, o, x;
        n = ~(av & bv);
        o = ~(av | bv);
        x = ~(av ^ bv);
        case (f)
            1: x = 1'b0;
            2: n = 1'b1;
            3: o = 1'b1;
            4: begin n = ~n; o = ~o; x = ~x; end
            5: o = 1'b0;
            default: ;
        endcase
        return {n, o, x};
    endfunction

    assign {nand_g, nor_g, xnor_g}    = gate_blk(a_o, b_o, fault);
    assign {nand0_g, nor0_g, xnor0_g} = gate_blk(a0_o, b0_o, fault0);

    gate_sweep_checker #(.SETTLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_nand_b  (nand_g),
        .a_nor_b   (nor_g),
        .a_xnor_b  (xnor_g),
        .a         (a_o),
        .b         (b_o),
        .busy      (busy_o),
        .done      (done_o),
        .pass      (pass_o),
        .err_count (cnt_o),
        .err_mask  (mask_o)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start0),
        .a_nand_b  (nand0_g),
        .a_nor_b   (nor0_g),
        .a_xnor_b  (xnor0_g),
        .a         (a0_o),
        .b         (b0_o),
        .busy      (busy0_o),
        .done      (done0_o),
        .pass      (pass0_o),
        .err_count (cnt0_o),
        .err_mask  (mask0_o)
    );

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Sweep on dut (SETTLE_CYCLES=2). Start is sampled at edge 0; an optional
    // extra start pulse is sampled at edge restart_edge. Returns the edge at
    // which done rose (-1 on timeout). a/b are checked every busy cycle.
    task automatic sweep(input int f, input int restart_edge, output int done_edge);
        int ab_bad;
        fault = f;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy at start edge", int'(busy_o), 1);
        check("ab at start edge", int'({a_o, b_o}), 0);
        done_edge = -1;
        ab_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == restart_edge) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (done_o) begin
                done_edge = k;
                break;
            end
            if (int'({a_o, b_o}) != ((k / 3) % 4)) ab_bad++;
        end
        check("ab stepping during sweep", ab_bad, 0);
    endtask

    // Sweep on dut0 (SETTLE_CYCLES=0): one vector per cycle.
    task automatic sweep0(input int f, output int done_edge);
        int ab_bad;
        fault0 = f;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        done_edge = -1;
        ab_bad = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done0_o) begin
                done_edge = k;
                break;
            end
            if (int'({a0_o, b0_o}) != k) ab_bad++;
        end
        check("s0 ab stepping", ab_bad, 0);
    endtask

    typedef struct {
        int fault;
        int exp_cnt;
        int exp_mask;
        int exp_pass;
        int exp_done_edge;
        int exp_ab;
    } vec_t;

    vec_t vecs[6];
    int   de;

    initial begin
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        vecs[0] = '{0, 0, 4'b0000, 1, 12, 3};
        vecs[1] = '{1, 1, 4'b0001, 0,  3, 0};
        vecs[2] = '{2, 1, 4'b1000, 0, 12, 3};
        vecs[3] = '{3, 1, 4'b0010, 0,  6, 1};
        vecs[4] = '{4, 1, 4'b0001, 0,  3, 0};
        vecs[5] = '{5, 1, 4'b0001, 0,  3, 0};
`else
        vecs[0] = '{0, 0, 4'b0000, 1, 12, 3};
        vecs[1] = '{1, 2, 4'b1001, 0, 12, 3};
        vecs[2] = '{2, 1, 4'b1000, 0, 12, 3};
        vecs[3] = '{3, 3, 4'b1110, 0, 12, 3};
        vecs[4] = '{4, 4, 4'b1111, 0, 12, 3};
        vecs[5] = '{5, 1, 4'b0001, 0, 12, 3};
`endif

        // Reset values on both instances.
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", int'({a_o, b_o, busy_o, done_o, pass_o, cnt_o, mask_o}), 0);
        check("reset outputs s0", int'({a0_o, b0_o, busy0_o, done0_o, pass0_o, cnt0_o, mask0_o}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle stays idle", int'({busy_o, done_o}), 0);

        // Table-driven fault sweeps.
        for (int i = 0; i < 6; i++) begin
            sweep(vecs[i].fault, 0, de);
            check($sformatf("v%0d done edge", i), de, vecs[i].exp_done_edge);
            check($sformatf("v%0d err_count", i), int'(cnt_o), vecs[i].exp_cnt);
            check($sformatf("v%0d err_mask", i), int'(mask_o), vecs[i].exp_mask);
            check($sformatf("v%0d pass", i), int'(pass_o), vecs[i].exp_pass);
            check($sformatf("v%0d busy", i), int'(busy_o), 0);
            check($sformatf("v%0d final ab", i), int'({a_o, b_o}), vecs[i].exp_ab);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d done held", i), int'({done_o, pass_o, mask_o}),
                  (1 << 5) | (vecs[i].exp_pass << 4) | vecs[i].exp_mask);
        end

        // Start pulsed mid-sweep at edge 5 is ignored.
        sweep(0, 5, de);
        check("restart ignored done edge", de, 12);
        check("restart ignored pass", int'(pass_o), 1);

        // Start held high: DONE lasts exactly one cycle, next sweep follows.
        fault = 0;
        start = 1'b1;
        de = -1;
        for (int k = 0; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done_o) begin
                de = k;
                break;
            end
        end
        check("held start done edge", de, 12);
        @(posedge clk); #1;
        check("held start restart", int'({done_o, busy_o, a_o, b_o}), 4'b0100);
        start = 1'b0;
        de = -1;
        for (int k = 14; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done_o) begin
                de = k;
                break;
            end
        end
        check("held start 2nd done edge", de, 25);
        check("held start 2nd pass", int'(pass_o), 1);

        // Asynchronous reset at edge 7 mid-sweep.
        fault = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("busy before reset", int'(busy_o), 1);
        rst_n = 1'b0;
        #1;
        check("async reset clears", int'({a_o, b_o, busy_o, done_o, pass_o, cnt_o, mask_o}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        sweep(0, 0, de);
        check("after reset done edge", de, 12);
        check("after reset pass", int'({pass_o, cnt_o, mask_o}), 8'h80);

        // SETTLE_CYCLES=0 instance.
        sweep0(0, de);
        check("s0 done edge", de, 4);
        check("s0 pass", int'({pass0_o, cnt0_o, mask0_o}), 8'h80);
        sweep0(1, de);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        check("s0 xnor fault done edge", de, 1);
        check("s0 xnor fault results", int'({pass0_o, cnt0_o, mask0_o}), 8'h11);
`else
        check("s0 xnor fault done edge", de, 4);
        check("s0 xnor fault results", int'({pass0_o, cnt0_o, mask0_o}), 8'h29);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
